// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state encoding and the divide-by-zero result rule.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULTU = 3'b000,
    MD_MULT  = 3'b001,
    MD_DIVU  = 3'b010,
    MD_DIV   = 3'b011,
    MD_MADDU = 3'b100,
    MD_MADD  = 3'b101,
    MD_MSUBU = 3'b110,
    MD_MSUB  = 3'b111
  } md_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  // On divide by zero every quotient bit takes this value; the remainder
  // returns the dividend unchanged.
  localparam logic MD_DIV0_QUO_BIT = 1'b1;

  function automatic logic md_is_div(input logic [2:0] m);
    return (m[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/md_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and shift the quotient bit in.
module md_div_step
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH:0]   o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH+1:0] w_shift;
  logic [WIDTH+1:0] w_diff;

  // Trial subtraction; a borrow out of the top bit means the divisor did not fit.
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_diff  = w_shift - {2'b00, i_div};
    if (w_diff[WIDTH+1]) begin
      o_rem = w_shift[WIDTH:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end else begin
      o_rem = w_diff[WIDTH:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative multiply/divide unit owning HI/LO, with mthi/mtlo writes,
// one-level write undo, cancel and a done pulse on every commit.
// Optional feature macro: MD_MADD_EN enables madd/maddu/msub/msubu on the
// multiply path; without it a start with mode[2]=1 is ignored.
module multdiv_iter
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_EXTRA  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             wsel,
  input  logic [WIDTH-1:0] wd,
  input  logic             cancel,
  input  logic             undo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > WIDTH) ? MUL_CYCLES : WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  md_state_e        r_st, st_nx;
  logic [CNT_W-1:0] r_cnt, cnt_nx;
  logic             r_busy, r_done;
  logic [WIDTH-1:0] r_hi, r_lo, r_sh_hi, r_sh_lo;
  logic             r_sv;
  logic [WIDTH-1:0] r_a, r_b, r_quo;
  logic [WIDTH:0]   r_rem;
  logic             r_sgn, r_neg_q, r_neg_r, r_dz;
`ifdef MD_MADD_EN
  logic             r_acc, r_sub;
`endif

  logic               w_mode_ok, w_start, w_step_en, w_commit;
  logic [WIDTH-1:0]   w_res_hi, w_res_lo, w_base_hi, w_base_lo;
  logic [WIDTH:0]     w_rem_nx;
  logic [WIDTH-1:0]   w_quo_nx, w_fix_q, w_fix_r;
  logic [2*WIDTH-1:0] w_pa, w_pb, w_prod, w_mul_res;

`ifdef MD_MADD_EN
  assign w_mode_ok = 1'b1;
`else
  assign w_mode_ok = ~mode[2];
`endif

  md_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_b),
    .o_rem (w_rem_nx),
    .o_quo (w_quo_nx)
  );

  // Sign-extending the operands to 2*WIDTH makes the low half of an
  // unsigned product equal the signed product.
  assign w_pa   = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_pb   = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod = w_pa * w_pb;
`ifdef MD_MADD_EN
  assign w_mul_res = !r_acc ? w_prod :
                     r_sub  ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
`else
  assign w_mul_res = w_prod;
`endif

  assign w_fix_q = r_neg_q ? neg(r_quo) : r_quo;
  assign w_fix_r = r_neg_r ? neg(r_rem[WIDTH-1:0]) : r_rem[WIDTH-1:0];

  // An undo in the same cycle as a write is applied first, so the write
  // and the new shadow both start from the restored values.
  assign w_base_hi = (undo && r_sv) ? r_sh_hi : r_hi;
  assign w_base_lo = (undo && r_sv) ? r_sh_lo : r_lo;

  // Next-state, counter and commit decode; cancel or a write aborts any
  // in-flight operation without committing.
  always_comb begin
    st_nx     = r_st;
    cnt_nx    = r_cnt;
    w_start   = 1'b0;
    w_step_en = 1'b0;
    w_commit  = 1'b0;
    w_res_hi  = r_hi;
    w_res_lo  = r_lo;
    case (r_st)
      ST_IDLE: begin
        if (start && !cancel && w_mode_ok) begin
          w_start = 1'b1;
          if (md_is_div(mode)) begin
            st_nx  = ST_DIV;
            cnt_nx = CNT_W'(WIDTH);
          end else begin
            st_nx  = ST_MUL;
            cnt_nx = CNT_W'(MUL_CYCLES);
          end
        end
      end
      ST_MUL: begin
        cnt_nx = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_commit = 1'b1;
          st_nx    = ST_IDLE;
          w_res_hi = w_mul_res[2*WIDTH-1:WIDTH];
          w_res_lo = w_mul_res[WIDTH-1:0];
        end
      end
      ST_DIV: begin
        if (r_dz) begin
          w_commit = 1'b1;
          st_nx    = ST_IDLE;
          cnt_nx   = '0;
          w_res_hi = r_a;
          w_res_lo = {WIDTH{MD_DIV0_QUO_BIT}};
        end else begin
          w_step_en = 1'b1;
          cnt_nx    = r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            if (DIV_EXTRA != 0) begin
              st_nx = ST_FIX;
            end else begin
              w_commit = 1'b1;
              st_nx    = ST_IDLE;
              w_res_hi = w_rem_nx[WIDTH-1:0];
              w_res_lo = w_quo_nx;
            end
          end
        end
      end
      ST_FIX: begin
        w_commit = 1'b1;
        st_nx    = ST_IDLE;
        w_res_hi = w_fix_r;
        w_res_lo = w_fix_q;
      end
      default: st_nx = ST_IDLE;
    endcase
    if ((r_st != ST_IDLE) && (cancel || we)) begin
      st_nx     = ST_IDLE;
      cnt_nx    = '0;
      w_step_en = 1'b0;
      w_commit  = 1'b0;
    end
  end

  // State register with registered busy and done.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_st   <= st_nx;
      r_cnt  <= cnt_nx;
      r_busy <= (st_nx != ST_IDLE);
      r_done <= w_commit;
    end
  end

  // Operand latch at start, then one restoring step per divide cycle.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_sgn   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
`ifdef MD_MADD_EN
      r_acc   <= 1'b0;
      r_sub   <= 1'b0;
`endif
    end else if (w_start) begin
      r_a   <= a;
      r_sgn <= mode[0];
`ifdef MD_MADD_EN
      r_acc <= mode[2];
      r_sub <= mode[1];
`endif
      if (md_is_div(mode)) begin
        r_b     <= (mode[0] && b[WIDTH-1]) ? neg(b) : b;
        r_quo   <= (mode[0] && a[WIDTH-1]) ? neg(a) : a;
        r_rem   <= '0;
        r_neg_q <= mode[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r <= mode[0] & a[WIDTH-1];
        r_dz    <= (b == '0);
      end else begin
        r_b <= b;
      end
    end else if (w_step_en) begin
      r_rem <= w_rem_nx;
      r_quo <= w_quo_nx;
    end
  end

  // HI/LO, shadow copy and undo; a write takes precedence since it aborts
  // any commit, and a commit invalidates the shadow.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_sh_hi <= '0;
      r_sh_lo <= '0;
      r_sv    <= 1'b0;
    end else if (we) begin
      r_sh_hi <= w_base_hi;
      r_sh_lo <= w_base_lo;
      r_sv    <= 1'b1;
      r_hi    <= wsel ? wd : w_base_hi;
      r_lo    <= wsel ? w_base_lo : wd;
    end else if (w_commit) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
      r_sv <= 1'b0;
    end else if (undo && r_sv) begin
      r_hi <= r_sh_hi;
      r_lo <= r_sh_lo;
      r_sv <= 1'b0;
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
